core_load_store_unit: RTL and testbench
=======================================

// Module: core_load_store_unit
// PURPOSE
//  Memory stage directly downstream of the execute unit. Takes the ALU result (effective
//  address or plain result) and performs RV64 loads/stores over a valid/ready data-memory port.
//  Handles byte-lane alignment, load sign/zero extension and misalignment checks, then drives
//  the writeback port. Non-memory ops pass through with a single register stage.
// PARAMETERS
//  TIMEOUT_CYC  256  max cycles in WAIT before the access is aborted with exc_access
// PORTS
//  clk             in   1   core clock; all state updates on rising edge
//  rst_n           in   1   reset, asynchronous, active-low
//  in_valid        in   1   execute result valid
//  in_ready        out  1   stage can accept; high only in IDLE
//  opcode          in   7   instruction opcode
//  funct3          in   3   size / sign select
//  alu_result      in   64  effective address (LOAD/STORE) or result (others)
//  store_data      in   64  rs2 value for stores
//  rd              in   5   destination register
//  mem_req_valid   out  1   memory request valid
//  mem_req_ready   in   1   memory accepts request
//  mem_req_addr    out  64  doubleword-aligned address: {alu_result[63:3],3'b0}
//  mem_req_we      out  1   1 = store
//  mem_req_wdata   out  64  store data shifted to byte lane
//  mem_req_wstrb   out  8   byte enables
//  mem_resp_valid  in   1   response valid (one per accepted request, stores included)
//  mem_resp_rdata  in   64  full doubleword read data
//  mem_resp_err    in   1   bus error, qualified by mem_resp_valid
//  wb_valid        out  1   one-cycle writeback pulse
//  wb_we           out  1   register write enable (0 for stores, rd==0, exceptions)
//  wb_rd           out  5   destination register
//  wb_data         out  64  writeback value
//  exc_misaligned  out  1   misaligned access, qualified by wb_valid
//  exc_access      out  1   bus error or timeout, qualified by wb_valid
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except in_ready=1; timeout counter 0.
//  - FSM: IDLE -> (accept when in_valid&in_ready) -> DONE | REQ.
//    - Non-memory opcode: DONE next cycle, wb_data=alu_result, wb_we=(rd!=0).
//    - LOAD(0000011)/STORE(0100011) aligned: REQ.
//    - Misaligned (H: a[0], W: a[1:0], D: a[2:0] non-zero) or LOAD funct3=111 or STORE
//      funct3[2]=1: DONE with exc_misaligned=1 (illegal funct3 also flagged here), wb_we=0,
//      no bus request.
//  - REQ: mem_req_valid=1, payload held stable until mem_req_ready; on handshake -> WAIT.
//  - WAIT: on mem_resp_valid -> DONE. Err -> exc_access=1, wb_we=0.
//    - Load: wb_data = extend(rdata >> 8*a[2:0]): LB/LH/LW signed, LBU/LHU/LWU zero, LD raw.
//    - Counter increments each WAIT cycle; reaching TIMEOUT_CYC -> DONE with exc_access=1.
//      A later stray response is ignored.
//  - DONE: wb_valid=1 for exactly one cycle -> IDLE. Writeback has no backpressure.
//  - Store lanes: wstrb = {1,3,15,255}[size] << a[2:0]; wdata = store_data << 8*a[2:0].
//  - mem_resp_valid outside WAIT is ignored.
//  - Latency: pass-through 1 cycle; memory op = 1 + request-wait + response latency + 1.
//  - Reset mid-transaction aborts immediately to IDLE; the outstanding response is dropped
//    by the WAIT-only rule.
// STRUCTURE
//  - Package core_pkg:
//    - OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM constants
//    - F3_B/H/W/D/BU/HU/WU funct3 constants
//    - lsu_state_e {IDLE,REQ,WAIT,DONE}
//  - Sub-module core_load_align: combinational rdata shift + sign/zero extend, (rdata, off[2:0],
//    funct3) -> data.
//  - The FSM, lane generation and timeout counter stay in this module.
// TESTING
//  - ADD pass-through: alu_result=0x1234, rd=5 -> wb_valid 1 cycle later, wb_data=0x1234, wb_we=1.
//  - LB a=0x1003, rdata=0x0000_0000_8000_0000 -> wb_data=0xFFFF_FFFF_FFFF_FF80.
//    Same with LBU -> wb_data=0x80.
//  - SH a=0x2006, store_data=0xBEEF -> wstrb=8'hC0, wdata=0xBEEF_0000_0000_0000,
//    addr=0x2000, wb_we=0.
//  - LW a=0x3002 -> exc_misaligned=1, mem_req_valid never asserted, in_ready back to 1
//    after 2 cycles.
//  - mem_req_ready low 5 cycles -> payload stable throughout. Then mem_resp_err=1 ->
//    exc_access=1, wb_we=0.
//  - No response for TIMEOUT_CYC cycles -> exc_access=1. rst_n low during WAIT -> outputs
//    0 and in_ready=1 asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// Shared opcode/funct3 constants, LSU state type and lane helpers for the memory stage.
package core_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

    // size is funct3[1:0]: 0=byte, 1=half, 2=word, 3=double
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic r;
        case (size)
            2'd0:    r = 1'b0;
            2'd1:    r = off[0];
            2'd2:    r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] lane_strb(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/core_load_align.sv
// Moves the addressed bytes of a load doubleword to bit 0 and sign/zero extends by funct3.
module core_load_align
    import core_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (funct3)
            F3_B:    data = {{56{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    data = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   data = {56'd0, shifted[7:0]};
            F3_HU:   data = {48'd0, shifted[15:0]};
            F3_WU:   data = {32'd0, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/core_load_store_unit.sv
// RV64 memory stage: pass-through for ALU ops, valid/ready data-memory access for loads/stores,
// with misalignment, bus-error and timeout exceptions reported on a one-cycle writeback pulse.
module core_load_store_unit
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [63:0] alu_result,
    input  logic [63:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    input  logic        mem_resp_err,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        exc_misaligned,
    output logic        exc_access
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    lsu_state_e      state;
    logic [CntW-1:0] cnt;
    logic [2:0]      off_q;
    logic [2:0]      f3_q;
    logic            is_load_q;
    logic [63:0]     load_data;

    logic is_load, is_store, is_mem, mem_fault;

    always_comb begin
        is_load   = (opcode == OPC_LOAD);
        is_store  = (opcode == OPC_STORE);
        is_mem    = is_load | is_store;
        // LOAD funct3=111 and any STORE with funct3[2] set are illegal; reported as misaligned
        mem_fault = (is_load ? (funct3 == 3'b111) : funct3[2])
                  | is_misaligned(funct3[1:0], alu_result[2:0]);
    end

    assign in_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign wb_valid      = (state == DONE);

    core_load_align u_align (
        .rdata  (mem_resp_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            off_q          <= '0;
            f3_q           <= '0;
            is_load_q      <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_we     <= 1'b0;
            mem_req_wdata  <= '0;
            mem_req_wstrb  <= '0;
            wb_we          <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            exc_misaligned <= 1'b0;
            exc_access     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        wb_rd          <= rd;
                        off_q          <= alu_result[2:0];
                        f3_q           <= funct3;
                        is_load_q      <= is_load;
                        cnt            <= '0;
                        wb_we          <= 1'b0;
                        wb_data        <= '0;
                        exc_misaligned <= 1'b0;
                        exc_access     <= 1'b0;
                        if (!is_mem) begin
                            wb_data <= alu_result;
                            wb_we   <= (rd != 5'd0);
                            state   <= DONE;
                        end else if (mem_fault) begin
                            exc_misaligned <= 1'b1;
                            state          <= DONE;
                        end else begin
                            mem_req_addr  <= {alu_result[63:3], 3'b000};
                            mem_req_we    <= is_store;
                            mem_req_wstrb <= lane_strb(funct3[1:0], alu_result[2:0]);
                            mem_req_wdata <= is_store ? (store_data << {alu_result[2:0], 3'b000})
                                                      : 64'd0;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state <= DONE;
                        if (mem_resp_err) begin
                            exc_access <= 1'b1;
                        end else if (is_load_q) begin
                            wb_data <= load_data;
                            wb_we   <= (wb_rd != 5'd0);
                        end
                    end else if (cnt == CntLast) begin
                        exc_access <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_load_store_unit.sv
// Directed, table-driven bench for core_load_store_unit plus stall/error/timeout/reset sequences.
module tb_core_load_store_unit;
    import core_pkg::*;

    localparam int unsigned TO = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [63:0] alu_result = '0;
    logic [63:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_rdata = '0;
    logic        mem_resp_err = 1'b0;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        exc_misaligned;
    logic        exc_access;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .opcode         (opcode),
        .funct3         (funct3),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .rd             (rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err),
        .wb_valid       (wb_valid),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .exc_misaligned (exc_misaligned),
        .exc_access     (exc_access)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic [63:0] rdata;
        bit          req;
        bit          st;
        logic [7:0]  strb;
        logic [63:0] wdata;
        bit          wbwe;
        bit          chkd;
        logic [63:0] wbd;
        bit          mis;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] sd, input logic [4:0] r);
        opcode = opc; funct3 = f3; alu_result = a; store_data = sd; rd = r; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        issue(v.opc, v.f3, v.a, v.sd, v.rd);
        if (v.req) begin
            chk({t, " req_valid"}, mem_req_valid, 1);
            chk({t, " req_addr"}, mem_req_addr, v.a & ~64'h7);
            chk({t, " req_we"}, mem_req_we, v.st);
            if (v.st) begin
                chk({t, " wstrb"}, mem_req_wstrb, v.strb);
                chk({t, " wdata"}, mem_req_wdata, v.wdata);
            end
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            chk({t, " req_dropped"}, mem_req_valid, 0);
            mem_resp_valid = 1'b1; mem_resp_rdata = v.rdata; mem_resp_err = 1'b0;
            tick();
            mem_resp_valid = 1'b0;
        end else begin
            chk({t, " no_req"}, mem_req_valid, 0);
        end
        chk({t, " wb_valid"}, wb_valid, 1);
        chk({t, " in_ready_busy"}, in_ready, 0);
        chk({t, " wb_rd"}, wb_rd, v.rd);
        chk({t, " wb_we"}, wb_we, v.wbwe);
        chk({t, " exc_mis"}, exc_misaligned, v.mis);
        chk({t, " exc_acc"}, exc_access, 0);
        if (v.chkd) chk({t, " wb_data"}, wb_data, v.wbd);
        tick();
        chk({t, " wb_pulse_end"}, wb_valid, 0);
        chk({t, " in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int n;
        //          opc         f3   a             sd                      rd  rdata
        //          req st strb wdata  wbwe chkd wbd  mis
        vecs[0]  = '{OPC_OP, 3'd0, 64'h1234, 64'h0, 5'd5, 64'h0,
                     0, 0, 8'h00, 64'h0, 1, 1, 64'h1234, 0};
        vecs[1]  = '{OPC_OP_IMM, 3'd0, 64'hDEAD, 64'h0, 5'd0, 64'h0,
                     0, 0, 8'h00, 64'h0, 0, 1, 64'hDEAD, 0};
        vecs[2]  = '{OPC_LOAD, F3_B, 64'h1003, 64'h0, 5'd7, 64'h0000_0000_8000_0000,
                     1, 0, 8'h00, 64'h0, 1, 1, 64'hFFFF_FFFF_FFFF_FF80, 0};
        vecs[3]  = '{OPC_LOAD, F3_BU, 64'h1003, 64'h0, 5'd7, 64'h0000_0000_8000_0000,
                     1, 0, 8'h00, 64'h0, 1, 1, 64'h80, 0};
        vecs[4]  = '{OPC_STORE, F3_H, 64'h2006, 64'hBEEF, 5'd9, 64'h0,
                     1, 1, 8'hC0, 64'hBEEF_0000_0000_0000, 0, 0, 64'h0, 0};
        vecs[5]  = '{OPC_LOAD, F3_H, 64'h1006, 64'h0, 5'd8, 64'h8001_0000_0000_0000,
                     1, 0, 8'h00, 64'h0, 1, 1, 64'hFFFF_FFFF_FFFF_8001, 0};
        vecs[6]  = '{OPC_LOAD, F3_WU, 64'h1004, 64'h0, 5'd10, 64'hF000_0000_1234_5678,
                     1, 0, 8'h00, 64'h0, 1, 1, 64'h0000_0000_F000_0000, 0};
        vecs[7]  = '{OPC_LOAD, F3_W, 64'h1004, 64'h0, 5'd11, 64'hF000_0000_1234_5678,
                     1, 0, 8'h00, 64'h0, 1, 1, 64'hFFFF_FFFF_F000_0000, 0};
        vecs[8]  = '{OPC_LOAD, F3_D, 64'h1008, 64'h0, 5'd12, 64'h0123_4567_89AB_CDEF,
                     1, 0, 8'h00, 64'h0, 1, 1, 64'h0123_4567_89AB_CDEF, 0};
        vecs[9]  = '{OPC_STORE, F3_B, 64'h2003, 64'h1122_3344_5566_7788, 5'd1, 64'h0,
                     1, 1, 8'h08, 64'h4455_6677_8800_0000, 0, 0, 64'h0, 0};
        vecs[10] = '{OPC_STORE, F3_W, 64'h2004, 64'hCAFE_BABE, 5'd2, 64'h0,
                     1, 1, 8'hF0, 64'hCAFE_BABE_0000_0000, 0, 0, 64'h0, 0};
        vecs[11] = '{OPC_STORE, F3_D, 64'h2000, 64'h0123_4567_89AB_CDEF, 5'd3, 64'h0,
                     1, 1, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h0, 0};
        vecs[12] = '{OPC_LOAD, F3_W, 64'h3002, 64'h0, 5'd4, 64'h0,
                     0, 0, 8'h00, 64'h0, 0, 0, 64'h0, 1};
        vecs[13] = '{OPC_LOAD, F3_D, 64'h3004, 64'h0, 5'd4, 64'h0,
                     0, 0, 8'h00, 64'h0, 0, 0, 64'h0, 1};
        vecs[14] = '{OPC_LOAD, 3'b111, 64'h3000, 64'h0, 5'd4, 64'h0,
                     0, 0, 8'h00, 64'h0, 0, 0, 64'h0, 1};
        vecs[15] = '{OPC_STORE, 3'b100, 64'h3000, 64'h0, 5'd4, 64'h0,
                     0, 0, 8'h00, 64'h0, 0, 0, 64'h0, 1};
        vecs[16] = '{OPC_STORE, F3_H, 64'h2001, 64'h0, 5'd4, 64'h0,
                     0, 0, 8'h00, 64'h0, 0, 0, 64'h0, 1};
        vecs[17] = '{OPC_LOAD, F3_B, 64'h1000, 64'h0, 5'd0, 64'h7F,
                     1, 0, 8'h00, 64'h0, 0, 0, 64'h0, 0};

        #2;
        chk("rst in_ready", in_ready, 1);
        chk("rst req_valid", mem_req_valid, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst exc", {exc_misaligned, exc_access}, 0);
        #20 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Request stalled for 5 cycles, then a bus error response
        issue(OPC_STORE, F3_W, 64'h4004, 64'h1122_3344, 5'd6);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d valid", i), mem_req_valid, 1);
            chk($sformatf("stall%0d addr", i), mem_req_addr, 64'h4000);
            chk($sformatf("stall%0d we", i), mem_req_we, 1);
            chk($sformatf("stall%0d strb", i), mem_req_wstrb, 8'hF0);
            chk($sformatf("stall%0d wdata", i), mem_req_wdata, 64'h1122_3344_0000_0000);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        tick();
        mem_resp_valid = 1'b1; mem_resp_err = 1'b1;
        tick();
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        chk("err wb_valid", wb_valid, 1);
        chk("err exc_access", exc_access, 1);
        chk("err exc_mis", exc_misaligned, 0);
        chk("err wb_we", wb_we, 0);
        tick();

        // Timeout: no response ever arrives
        issue(OPC_LOAD, F3_B, 64'h5000, 64'h0, 5'd3);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        n = 0;
        while (!wb_valid && n < 400) begin
            tick();
            n++;
        end
        chk("timeout cycles", n, TO);
        chk("timeout exc_access", exc_access, 1);
        chk("timeout wb_we", wb_we, 0);
        tick();
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h55;
        tick();
        mem_resp_valid = 1'b0;
        chk("stray wb_valid", wb_valid, 0);
        chk("stray in_ready", in_ready, 1);
        run_vec(vecs[0], 100);

        // Asynchronous reset while waiting for a response
        issue(OPC_LOAD, F3_D, 64'h6008, 64'h0, 5'd9);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst in_ready", in_ready, 1);
        chk("arst req_valid", mem_req_valid, 0);
        chk("arst req_addr", mem_req_addr, 0);
        chk("arst wb_valid", wb_valid, 0);
        chk("arst wb_rd", wb_rd, 0);
        chk("arst exc", {exc_misaligned, exc_access}, 0);
        #3 rst_n = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hAA;
        tick();
        mem_resp_valid = 1'b0;
        chk("arst drop wb_valid", wb_valid, 0);
        chk("arst drop in_ready", in_ready, 1);
        run_vec(vecs[8], 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
